// File: rtl/key_bcd_counter_pkg.sv
// Shared types and constants for the push-button driven four-digit BCD counter.
package key_bcd_counter_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam int         NUM_DIGITS          = 4;
   localparam bcd_digit_t BCD_MAX             = 4'd9;
   localparam int         DEBOUNCE_50MHZ_10MS = 500000;

endpackage

// File: rtl/key_debounce.sv
// One raw active-low key: two-flop synchroniser, stability counter and a
// single-cycle press pulse on each accepted released-to-pressed transition.
module key_debounce
   import key_bcd_counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_10MS
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic press
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_p0;
   logic          sync_p1;
   logic          stable_p2;
   logic          stable_p3;
   logic [CW-1:0] cnt_p2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0   <= 1'b1;
         sync_p1   <= 1'b1;
         stable_p2 <= 1'b1;
         stable_p3 <= 1'b1;
         cnt_p2    <= '0;
         press     <= 1'b0;
      end else begin
         // stage 0/1: metastability guard on the raw key
         sync_p0 <= key;
         sync_p1 <= sync_p0;
         // stage 2: any return to the accepted level restarts qualification
         if (sync_p1 == stable_p2) begin
            cnt_p2 <= '0;
         end else if (cnt_p2 == CNT_LAST) begin
            stable_p2 <= sync_p1;
            cnt_p2    <= '0;
         end else begin
            cnt_p2 <= cnt_p2 + 1'b1;
         end
         // stage 3: falling edge of the accepted level is the press
         stable_p3 <= stable_p2;
         press     <= stable_p3 & ~stable_p2;
      end
   end

endmodule

// File: rtl/key_bcd_counter.sv
// Four-digit BCD up/down counter stepped by debounced key presses; the
// registered digit outputs feed the seven-segment decoders directly.
module key_bcd_counter
   import key_bcd_counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_10MS
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic                    key_up,
   input  logic                    key_down,
   input  logic                    clear,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                    wrap
);

   logic                    up_evt;
   logic                    down_evt;
   logic [4*NUM_DIGITS-1:0] inc_val;
   logic [4*NUM_DIGITS-1:0] dec_val;
   logic                    all_max;
   logic                    all_zero;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
      .clk   (CLOCK_50),
      .rst   (reset),
      .key   (key_up),
      .press (up_evt)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_down (
      .clk   (CLOCK_50),
      .rst   (reset),
      .key   (key_down),
      .press (down_evt)
   );

   // A digit moves only when every lower digit is at its rollover value.
   always_comb begin : carry_chain
      logic       carry;
      logic       borrow;
      bcd_digit_t d;
      carry   = 1'b1;
      borrow  = 1'b1;
      d       = '0;
      inc_val = digits;
      dec_val = digits;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d = digits[4*i +: 4];
         if (carry)
            inc_val[4*i +: 4] = (d == BCD_MAX) ? bcd_digit_t'(0) : d + 4'd1;
         if (borrow)
            dec_val[4*i +: 4] = (d == 4'd0) ? BCD_MAX : d - 4'd1;
         carry  = carry & (d == BCD_MAX);
         borrow = borrow & (d == 4'd0);
      end
      all_max  = carry;
      all_zero = borrow;
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         digits <= '0;
         wrap   <= 1'b0;
      end else if (clear) begin
         digits <= '0;
         wrap   <= 1'b0;
      end else if (up_evt && down_evt) begin
         wrap <= 1'b0;
      end else if (up_evt) begin
         digits <= inc_val;
         wrap   <= all_max;
      end else if (down_evt) begin
         digits <= dec_val;
         wrap   <= all_zero;
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: doc/key_bcd_counter.md
# key_bcd_counter

Four-digit decimal (BCD) up/down counter driven by two raw push-buttons. It synchronises and debounces both keys, converts each debounced press into a single count event, and maintains a 0000–9999 value. It sits directly upstream of the seven-segment stage: each 4-bit digit output feeds one `dec_to_hex` instance driving HEX0–HEX3.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz). Legal range ≥ 1.
- `CLOCK_50  in  1`: sole clock, rising edge.
- `reset  in  1`: asynchronous, active-high reset.
- `key_up  in  1`: raw, asynchronous, active-low button (0 = pressed); increments the count.
- `key_down  in  1`: raw, asynchronous, active-low button; decrements the count.
- `clear  in  1`: synchronous, active-high; forces the count to 0000.
- `digits  out  16`: BCD count. `[3:0]` ones, `[7:4]` tens, `[11:8]` hundreds, `[15:12]` thousands. Each nibble is always 0–9.
- `wrap  out  1`: one-cycle pulse when the count wraps, either 9999→0000 or 0000→9999.

## Operation
- **Synchroniser:** two-flop chain per key. Reset value is 1 (released).
- **Debounce, per key:**
  - Holds a `stable` level (reset value 1) and a counter of width clog2(DEBOUNCE_CYCLES+1) (reset value 0).
  - While the synced input equals `stable`, the counter clears to 0.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES, `stable` takes the synced value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count, so no level change is accepted.
- **Press event:**
  - A registered one-cycle pulse fires on a `stable` 1→0 transition.
  - A release (0→1) produces no event.
  - Holding a key produces exactly one event; there is no auto-repeat.
- **Counter update priority:**
  1. `clear`: digits = 0, `wrap` = 0.
  2. Up and down events in the same cycle: no change, `wrap` = 0.
  3. Up event: BCD increment with carry ripple across digits (x9→(x+1)0). 9999→0000 with `wrap` = 1.
  4. Down event: BCD decrement with borrow ripple (x0→(x−1)9). 0000→9999 with `wrap` = 1.
  5. Otherwise: hold, `wrap` = 0.
- **Reset values:** `digits` = 16'h0000, `wrap` = 0, all internal state in the released/idle condition. Reset asserted mid-debounce or mid-press aborts it. After reset deassertion, a key still held low must re-qualify through the full debounce before it counts.

## Timing
- Raw key first sampled low at edge k:
  - Synchroniser output low at edge k+1.
  - `stable` flips at edge k+1+DEBOUNCE_CYCLES.
  - Press pulse high for the cycle after edge k+2+DEBOUNCE_CYCLES.
  - `digits` and `wrap` update at edge k+3+DEBOUNCE_CYCLES.
- `wrap` is high for exactly one cycle, coincident with the wrapped `digits` value.
- `clear` takes effect at the next edge (latency 1) and overrides a press pulse in the same cycle; that press is discarded.
- `digits` is fully registered with no combinational path from inputs, so it is safe to feed `dec_to_hex` directly.

## Structure
- **Shared package:**
  - `bcd_digit_t` (4-bit digit type).
  - `NUM_DIGITS` = 4.
  - `BCD_MAX` = 9.
  - Default debounce constant `DEBOUNCE_50MHZ_10MS` = 500000.
- **Sub-module `key_debounce`:** synchroniser, debounce counter, `stable` register and press pulse, parameterised by DEBOUNCE_CYCLES. Instantiated twice.
- **Top:** the BCD up/down counter with per-digit carry/borrow logic, built as a loop over `NUM_DIGITS`.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- **Reset and clean press:** assert reset, deassert, then drive `key_up` low for 20 cycles. Expect `digits` = 16'h0000 throughout reset, then 16'h0001 exactly at edge k+7 after the first low sample, with no further change while held.
- **Carry ripple and up-wrap:** preload 0999 via presses (or force), press up once, expect 16'h1000. From 9999, press up once: expect 16'h0000 with `wrap` high for exactly that one cycle.
- **Down-wrap and borrow:** from 0000, press down: expect 16'h9999 with a one-cycle `wrap`. From 1000, press down: expect 16'h0999.
- **Bounce rejection:** drive `key_up` low 3 / high 1 / low 3 / high 2 cycles, then low 30 cycles. Expect exactly one increment, timed from the start of the final low run. Release bounce produces no event.
- **Simultaneous events:** align `key_up` and `key_down` presses so both pulses coincide, with count at 0042. Expect 0042 unchanged and `wrap` = 0.
- **Clear priority and mid-operation reset:** assert `clear` in the same cycle as an up pulse at 0123, expect 0000. Assert reset 2 cycles into a debounce, deassert with the key held: expect the count to change only after a full fresh debounce (DEBOUNCE_CYCLES + 3 edges after the first post-reset sample).
